// File: rtl/aes_sha_host_if.sv
// aes_sha_host_if
//   Host-side wrapper around the AES/SHA3 Top byte-serial port. A host hands
//   over salt, password, message and mode in parallel. This block streams
//   them into Top one byte per cycle and gathers Top's 16-byte cipher and
//   32-byte HMAC back into parallel result registers.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   i_req             start a transaction (looked at only while idle)
//   i_mode            mode bit, latched when the request is accepted
//   i_salt/i_pw/i_msg parallel operands, most significant byte goes first
//   o_busy            high from accept until the result (or abort)
//   o_done / o_err    one-cycle pulses: results valid / wait timed out
//   o_cipher, o_hmac  captured results, first received byte in [7:0]
//   o_top_*           byte stream toward Top (data, start, mode)
//   i_top_*           byte stream from Top (data, valid, ien)
//   o_dbg_state       current FSM state, for observation only
//
// Top stream protocol (the only handshake in this block):
//   Outbound, a byte is transferred on every rising clock edge while
//   o_top_start is high. There is no back-pressure, so bursts are gap-free.
//   Top lowers i_top_ien once it has absorbed the key. A 1->0 transition of
//   i_top_ien releases the message burst.
//   Inbound, the first cycle with i_top_valid high starts the 16 cipher
//   bytes. After that the bytes are taken by count, without rechecking
//   valid. The HMAC begins on the next 0->1 transition of i_top_valid, and
//   its 32 bytes are also taken by count.
//   Each wait for Top is bounded by TIMEOUT cycles.

module aes_sha_host_if #(
  parameter int PW_LEN  = 15,
  parameter int TIMEOUT = 10000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic                i_mode,
  input  logic [127:0]        i_salt,
  input  logic [PW_LEN*8-1:0] i_pw,
  input  logic [127:0]        i_msg,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [127:0]        o_cipher,
  output logic [255:0]        o_hmac,
  output logic [7:0]          o_top_data,
  output logic                o_top_start,
  output logic                o_top_mode,
  input  logic [7:0]          i_top_data,
  input  logic                i_top_valid,
  input  logic                i_top_ien,
  output logic [3:0]          o_dbg_state
);

  localparam int          KW      = 128 + PW_LEN * 8;
  localparam logic [5:0]  KEY_LEN = 6'(16 + PW_LEN);
  localparam logic [13:0] TO_LAST = 14'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_SEND_KEY    = 4'd1,
    S_WAIT_KEY    = 4'd2,
    S_SEND_MSG    = 4'd3,
    S_WAIT_CIPHER = 4'd4,
    S_RECV_CIPHER = 4'd5,
    S_WAIT_HMAC   = 4'd6,
    S_RECV_HMAC   = 4'd7,
    S_DONE        = 4'd8
  } state_e;

  state_e         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [13:0]    wcnt_q, wcnt_d;
  logic [KW-1:0]  key_q, key_d;    // salt then password, shifted out MS-first
  logic [127:0]   msg_q, msg_d;
  logic           ien_q, valid_q;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           mode_q, mode_d;
  logic           start_q, start_d;
  logic [7:0]     data_q, data_d;
  logic [127:0]   cipher_q, cipher_d;
  logic [255:0]   hmac_q, hmac_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      key_q    <= '0;
      msg_q    <= '0;
      ien_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mode_q   <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= '0;
      cipher_q <= '0;
      hmac_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      key_q    <= key_d;
      msg_q    <= msg_d;
      ien_q    <= i_top_ien;
      valid_q  <= i_top_valid;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mode_q   <= mode_d;
      start_q  <= start_d;
      data_q   <= data_d;
      cipher_q <= cipher_d;
      hmac_q   <= hmac_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wcnt_d   = '0;          // the wait counter only survives inside a wait state
    key_d    = key_q;
    msg_d    = msg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    mode_d   = mode_q;
    start_d  = 1'b0;
    data_d   = '0;
    cipher_d = cipher_q;
    hmac_d   = hmac_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_req) begin
          key_d   = {i_salt, i_pw};
          msg_d   = i_msg;
          mode_d  = i_mode;
          busy_d  = 1'b1;
          state_d = S_SEND_KEY;
        end
      end

      S_SEND_KEY: begin
        if (cnt_q == KEY_LEN) begin
          cnt_d   = '0;
          state_d = S_WAIT_KEY;
        end else begin
          start_d = 1'b1;
          data_d  = key_q[KW-1 -: 8];
          key_d   = key_q << 8;
          cnt_d   = cnt_q + 6'd1;
        end
      end

      S_WAIT_KEY: begin
        if (ien_q && !i_top_ien) begin
          cnt_d   = '0;
          state_d = S_SEND_MSG;
        end else if (wcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          mode_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 14'd1;
        end
      end

      S_SEND_MSG: begin
        if (cnt_q == 6'd16) begin
          cnt_d   = '0;
          state_d = S_WAIT_CIPHER;
        end else begin
          start_d = 1'b1;
          data_d  = msg_q[127 -: 8];
          msg_d   = msg_q << 8;
          cnt_d   = cnt_q + 6'd1;
        end
      end

      S_WAIT_CIPHER: begin
        if (i_top_valid) begin
          cipher_d[7:0] = i_top_data;
          cnt_d         = '0;
          state_d       = S_RECV_CIPHER;
        end else if (wcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          mode_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 14'd1;
        end
      end

      // Byte 0 came in with the wait state, so cnt_q here counts from byte 1.
      S_RECV_CIPHER: begin
        cipher_d[{cnt_q[3:0] + 4'd1, 3'b000} +: 8] = i_top_data;
        if (cnt_q == 6'd14) begin
          cnt_d   = '0;
          state_d = S_WAIT_HMAC;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      S_WAIT_HMAC: begin
        if (!valid_q && i_top_valid) begin
          hmac_d[7:0] = i_top_data;
          cnt_d       = '0;
          state_d     = S_RECV_HMAC;
        end else if (wcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          mode_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 14'd1;
        end
      end

      S_RECV_HMAC: begin
        hmac_d[{cnt_q[4:0] + 5'd1, 3'b000} +: 8] = i_top_data;
        if (cnt_q == 6'd30) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        mode_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_cipher    = cipher_q;
  assign o_hmac      = hmac_q;
  assign o_top_data  = data_q;
  assign o_top_start = start_q;
  assign o_top_mode  = mode_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/aes_sha_host_if.md
Name: aes_sha_host_if

Overview:
- Host-side counterpart of the AES/SHA3 Top byte-serial interface.
- Takes parallel salt/password/message words from a host and streams them into Top's i_data/i_start/i_mode port.
- Collects Top's o_data stream (16-byte cipher, then 32-byte HMAC) into parallel result registers.
- Replaces the bench-level driver/collector; this is the integration wrapper for SoC-level use.

Parameters:
- PW_LEN, 15, password length in bytes (legal 1..32).
- TIMEOUT, 10000, max cycles spent in any wait state before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_req  in  1  transaction request; sampled only in IDLE
- i_mode  in  1  mode bit, latched on accept
- i_salt  in  128  salt; byte [127:120] sent first
- i_pw  in  PW_LEN*8  password; MS byte sent first
- i_msg  in  128  message; byte [127:120] sent first
- o_busy  out  1  high from accept until DONE
- o_done  out  1  one-cycle pulse, results valid
- o_err  out  1  one-cycle pulse on timeout abort
- o_cipher  out  128  captured cipher; first received byte in [7:0]
- o_hmac  out  256  captured HMAC; first received byte in [7:0]
- o_top_data  out  8  to Top i_data
- o_top_start  out  1  to Top i_start
- o_top_mode  out  1  to Top i_mode
- i_top_data  in  8  from Top o_data
- i_top_valid  in  1  from Top o_valid
- i_top_ien  in  1  from Top o_ien

Behaviour:
- Reset (rst_n=0 at posedge clk), from any state including mid-transfer:
  - All outputs go to 0: o_cipher, o_hmac, o_top_data, o_top_start, o_top_mode, o_busy, o_done, o_err.
  - FSM returns to IDLE; counters clear.
- All outputs are registered. ien_q and valid_q are 1-cycle delayed copies of i_top_ien and i_top_valid, used for edge detection.
- FSM states:
  - IDLE:
    - Accept when i_req=1: latch salt, pw, msg and mode; set o_busy=1.
    - Next cycle enters SEND_KEY. o_top_mode is driven with the latched mode from the accept edge until DONE.
  - SEND_KEY:
    - o_top_start=1; one byte per cycle: 16 salt bytes MS-first, then PW_LEN password bytes MS-first. Total 16+PW_LEN consecutive cycles, no gaps.
    - On the edge after the last byte: o_top_start=0, o_top_data=0, go to WAIT_KEY.
  - WAIT_KEY: wait for a falling edge of i_top_ien (ien_q=1, i_top_ien=0); then go to SEND_MSG.
  - SEND_MSG: o_top_start=1 for 16 cycles carrying msg bytes MS-first; then o_top_start=0 and go to WAIT_CIPHER.
  - WAIT_CIPHER: on the first cycle i_top_valid=1, capture that byte as byte 0 and go to RECV_CIPHER.
  - RECV_CIPHER:
    - Capture i_top_data each cycle into o_cipher[k*8+:8], 16 bytes total including byte 0.
    - Capture is count-driven; valid is not rechecked.
    - Then go to WAIT_HMAC.
  - WAIT_HMAC: wait for a rising edge of i_top_valid (valid_q=0, i_top_valid=1). That byte is HMAC byte 0; go to RECV_HMAC.
  - RECV_HMAC: capture 32 bytes total into o_hmac[k*8+:8]; then go to DONE.
  - DONE: o_done=1 and o_busy=0 for one cycle; return to IDLE.
- Byte counter is 6 bits and clears on every state change.
- Timeout: a 14-bit wait counter (sized for TIMEOUT) runs in WAIT_KEY, WAIT_CIPHER and WAIT_HMAC.
  - Reaching TIMEOUT: o_err pulses for one cycle, o_busy=0, go to IDLE.
  - o_cipher/o_hmac keep any partial contents.
- o_cipher and o_hmac hold their values until overwritten by the next transaction or reset.
- i_req while busy is ignored; no queueing.
- i_req held high through DONE: a new transaction is accepted the cycle IDLE is re-entered.
- Input words change after accept: no effect (latched copies are used).
- The Top reset is not driven by this block; the system asserts it between transactions.

Test Plan:
- Send order:
  - Stimulus: salt=128'h000102030405060708090a0b0c0d0e0f, pw=120'h101112131415161718191a1b1c1d1e, i_req pulse.
  - Response: o_top_start high exactly 31 cycles, o_top_data 00,01,…,0f,10,…,1e. After an ien fall, 16-cycle msg burst MS-first.
- Capture order:
  - Stimulus: Top model returns a0..af, then after a valid gap 00..1f.
  - Response: o_cipher=128'hafaeadacabaaa9a8a7a6a5a4a3a2a1a0; o_hmac=256'h1f1e…0100; o_done one pulse one cycle after last HMAC byte.
- Mode latch: i_mode=1 at accept, then 0 next cycle -> o_top_mode=1 throughout the transaction; back to 0 at IDLE.
- Timeout: i_top_ien never falls -> o_err pulse exactly TIMEOUT cycles after entering WAIT_KEY; o_busy=0; o_done never asserted.
- Reset mid-op: rst_n=0 during SEND_KEY byte 10 -> next cycle o_top_start=0, o_top_data=0, o_busy=0; a fresh i_req restarts from salt byte 00.
- Back-to-back: two requests with different salts and i_req held high -> second salt's byte 00 appears on o_top_data exactly 2 cycles after the first o_done pulse; results for both transactions are correct.
